mem_port_arbiter: RTL and testbench

- Shares the core's single memory port between instruction fetch (IF) and data access (D).
- Sits between the RISC-V core's fetch/LSU interfaces and the memory-side data port on top.
- Arbitrates, forwards one transaction at a time, and routes the response back to its owner.
- Handshake on every side: req/gnt for the address phase, rvalid for the response phase.

---
 rtl/mem_arb_pkg.sv | 8 +
 rtl/mem_arb_select.sv | 27 ++
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory-port arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {IDLE, REQ, RESP} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;
endpackage

// File: rtl/mem_arb_select.sv
// Combinational owner pick from the two request lines; zero latency, no backpressure.
// MEM_ARB_RR_EN: alternate on contention using rr_last, else data side always wins.
module mem_arb_select
  import mem_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   d_req,
  input  owner_t rr_last,
  output owner_t owner
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    owner = OWN_IF;
    if (if_req && d_req) begin
      owner = (rr_last == OWN_D) ? OWN_IF : OWN_D;
    end else if (d_req) begin
      owner = OWN_D;
    end
  end
`else
  logic rr_unused;
  assign rr_unused = (rr_last == OWN_D);
  assign owner     = d_req ? OWN_D : OWN_IF;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data; one transaction in flight, min 3 cycles each.
// Requesters are stalled via gnt; MEM_ARB_RR_EN selects round-robin instead of data-first priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                busy_o
);

  arb_state_t        state;
  owner_t            owner;
  owner_t            rr_last;
  owner_t            sel;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              in_req;
  logic              in_resp;
  logic              own_d;
  logic              gnt_hit;
  logic              resp_hit;

  mem_arb_select u_select (
    .if_req  (if_req_i),
    .d_req   (d_req_i),
    .rr_last (rr_last),
    .owner   (sel)
  );

  assign in_req   = (state == REQ);
  assign in_resp  = (state == RESP);
  assign own_d    = (owner == OWN_D);
  // Handshakes are masked during reset so an aborted transaction never completes.
  assign gnt_hit  = in_req && mem_gnt_i && !rst_i;
  assign resp_hit = in_resp && mem_rvalid_i && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req_i || d_req_i) begin
            owner <= sel;
            state <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt_i) state <= RESP;
        end
        RESP: begin
          if (mem_rvalid_i) begin
            state <= IDLE;
            if (own_d) d_rdata_q  <= mem_rdata_i;
            else       if_rdata_q <= mem_rdata_i;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)         rr_last <= OWN_D;
    else if (resp_hit) rr_last <= owner;
  end
`else
  assign rr_last = OWN_D;
`endif

  // Address phase follows the owner's live request fields; fetch is always a full-word read.
  assign mem_req_o   = in_req;
  assign mem_we_o    = in_req && own_d && d_we_i;
  assign mem_be_o    = !in_req ? '0 : (own_d ? d_be_i : '1);
  assign mem_addr_o  = !in_req ? '0 : (own_d ? d_addr_i : if_addr_i);
  assign mem_wdata_o = (in_req && own_d) ? d_wdata_i : '0;

  assign if_gnt_o    = gnt_hit && !own_d;
  assign d_gnt_o     = gnt_hit && own_d;
  assign if_rvalid_o = resp_hit && !own_d;
  assign d_rvalid_o  = resp_hit && own_d;
  assign if_rdata_o  = (resp_hit && !own_d) ? mem_rdata_i : if_rdata_q;
  assign d_rdata_o   = (resp_hit && own_d) ? mem_rdata_i : d_rdata_q;
  assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: bench acts as memory and both requesters.
// Honours MEM_ARB_RR_EN in its reference arbitration model.
module tb_mem_port_arbiter;
  localparam int LIMIT = 20;
`ifdef MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i, d_req_i, d_we_i, mem_gnt_i, mem_rvalid_i;
  logic [31:0] if_addr_i, d_addr_i, d_wdata_i, mem_rdata_i;
  logic [3:0]  d_be_i;
  logic        if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, mem_req_o, mem_we_o, busy_o;
  logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int if_gnt_n = 0, d_gnt_n = 0, if_rv_n = 0, d_rv_n = 0;
  bit if_pend = 1'b0, d_pend = 1'b0;

  // Reference model state: arbitration history and last data delivered to each side.
  bit          m_rr_last_d = 1'b1;
  logic [31:0] m_if_rd = '0;
  logic [31:0] m_d_rd = '0;

  typedef struct {
    bit          timeout;
    int          wait_n;
    int          start;
    logic [31:0] addr, wdata, if_rd, d_rd;
    logic        we, if_gnt, d_gnt, if_rv, d_rv, busy;
    logic [3:0]  be;
  } obs_t;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Pulse counters and requester-protocol watch, sampled mid low phase.
  always @(negedge clk_i) begin
    #3;
    if (if_gnt_o === 1'b1) if_gnt_n <= if_gnt_n + 1;
    if (d_gnt_o === 1'b1) d_gnt_n <= d_gnt_n + 1;
    if (if_rvalid_o === 1'b1) if_rv_n <= if_rv_n + 1;
    if (d_rvalid_o === 1'b1) d_rv_n <= d_rv_n + 1;
    if (!rst_i && if_pend) assert (if_req_i) else $error("protocol: if_req_i dropped before grant");
    if (!rst_i && d_pend) assert (d_req_i) else $error("protocol: d_req_i dropped before grant");
    if_pend <= !rst_i && if_req_i && (if_gnt_o !== 1'b1);
    d_pend  <= !rst_i && d_req_i && (d_gnt_o !== 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  function automatic bit pick_d(input bit ir, input bit dr, input bit last_d);
    if (ir && dr) return RR_EN ? !last_d : 1'b1;
    return dr;
  endfunction

  task automatic model_reset();
    m_rr_last_d = 1'b1;
    m_if_rd = '0;
    m_d_rd = '0;
  endtask

  task automatic model_done(input bit own_d, input logic [31:0] rd);
    m_rr_last_d = own_d;
    if (own_d) m_d_rd = rd;
    else       m_if_rd = rd;
  endtask

  // Plays the memory for one transaction: gw idle REQ cycles before gnt, rvalid rw cycles after gnt.
  task automatic run_txn(input int gw, input int rw, input logic [31:0] rd, input bit exp_d,
                         output obs_t o);
    o = '{default: '0};
    @(negedge clk_i); #1;
    while (mem_req_o !== 1'b1 && o.wait_n < LIMIT) begin
      @(negedge clk_i); #1;
      o.wait_n++;
    end
    if (mem_req_o !== 1'b1) begin
      o.timeout = 1'b1;
      if_req_i = 1'b0;
      d_req_i = 1'b0;
      return;
    end
    o.start = cyc;
    o.addr = mem_addr_o; o.we = mem_we_o; o.be = mem_be_o; o.wdata = mem_wdata_o;
    repeat (gw) begin @(negedge clk_i); #1; end
    mem_gnt_i = 1'b1; #1;
    o.if_gnt = if_gnt_o; o.d_gnt = d_gnt_o;
    @(negedge clk_i);
    mem_gnt_i = 1'b0;
    if (o.if_gnt === 1'b1) if_req_i = 1'b0;
    if (o.d_gnt === 1'b1) d_req_i = 1'b0;
    if (o.if_gnt !== 1'b1 && o.d_gnt !== 1'b1) begin
      if (exp_d) d_req_i = 1'b0; else if_req_i = 1'b0;
    end
    repeat (rw - 1) @(negedge clk_i);
    mem_rvalid_i = 1'b1; mem_rdata_i = rd; #1;
    o.if_rv = if_rvalid_o; o.d_rv = d_rvalid_o; o.if_rd = if_rdata_o; o.d_rd = d_rdata_o;
    o.busy = busy_o;
    @(negedge clk_i);
    mem_rvalid_i = 1'b0; mem_rdata_i = $urandom();
  endtask

  task automatic test_reset();
    rst_i = 1'b1; if_req_i = 1'b1; d_req_i = 1'b0; d_we_i = 1'b0; d_be_i = '0;
    if_addr_i = 32'h44; d_addr_i = '0; d_wdata_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (3) @(negedge clk_i);
    #1;
    checks++; if ({busy_o, mem_req_o} !== 2'b00) begin errors++; $display("FAIL reset_hold: busy/mem_req=%b want 00", {busy_o, mem_req_o}); end
    if_req_i = 1'b0; rst_i = 1'b0;
    model_reset();
    @(negedge clk_i); #1;
    checks++; if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== '0) begin errors++; $display("FAIL reset_mem: req=%b we=%b be=%h addr=%h wdata=%h want all 0", mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o); end
    checks++; if ({if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, busy_o} !== 5'b0) begin errors++; $display("FAIL reset_ctl: gnt/rvalid/busy=%b want 00000", {if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, busy_o}); end
    checks++; if ({if_rdata_o, d_rdata_o} !== 64'h0) begin errors++; $display("FAIL reset_rdata: if=%h d=%h want 0", if_rdata_o, d_rdata_o); end
  endtask

  task automatic test_single_fetch();
    obs_t o;
    int g_if, g_d, v_if, v_d;
    g_if = if_gnt_n; g_d = d_gnt_n; v_if = if_rv_n; v_d = d_rv_n;
    if_req_i = 1'b1; if_addr_i = 32'h100;
    run_txn(2, 3, 32'hDEADBEEF, 1'b0, o);
    checks++; if (o.timeout !== 1'b0 || o.wait_n !== 0) begin errors++; $display("FAIL fetch_latency: timeout=%0d extra_cycles=%0d want 0/0", o.timeout, o.wait_n); end
    checks++; if ({o.addr, o.we, o.be, o.wdata} !== {32'h100, 1'b0, 4'hF, 32'h0}) begin errors++; $display("FAIL fetch_mem: addr=%h we=%b be=%h wdata=%h want 100/0/f/0", o.addr, o.we, o.be, o.wdata); end
    checks++; if ({o.if_gnt, o.d_gnt, o.if_rv, o.d_rv} !== 4'b1010) begin errors++; $display("FAIL fetch_hs: ifgnt,dgnt,ifrv,drv=%b want 1010", {o.if_gnt, o.d_gnt, o.if_rv, o.d_rv}); end
    checks++; if (o.if_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_rdata: got %h want deadbeef", o.if_rd); end
    checks++; if ({if_gnt_n - g_if, if_rv_n - v_if, d_gnt_n - g_d, d_rv_n - v_d} !== {32'd1, 32'd1, 32'd0, 32'd0}) begin errors++; $display("FAIL fetch_pulses: ifgnt=%0d ifrv=%0d dgnt=%0d drv=%0d want 1 1 0 0", if_gnt_n - g_if, if_rv_n - v_if, d_gnt_n - g_d, d_rv_n - v_d); end
    model_done(1'b0, 32'hDEADBEEF);
  endtask

  task automatic test_data_write();
    obs_t o;
    int g_if, g_d, v_if, v_d;
    g_if = if_gnt_n; g_d = d_gnt_n; v_if = if_rv_n; v_d = d_rv_n;
    d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'h3; d_addr_i = 32'h2000; d_wdata_i = 32'h1234;
    run_txn(1, 2, 32'h0000_A5A5, 1'b1, o);
    checks++; if (o.timeout !== 1'b0) begin errors++; $display("FAIL write_timeout: no mem_req_o within %0d cycles", LIMIT); end
    checks++; if ({o.addr, o.we, o.be, o.wdata} !== {32'h2000, 1'b1, 4'h3, 32'h1234}) begin errors++; $display("FAIL write_mem: addr=%h we=%b be=%h wdata=%h want 2000/1/3/1234", o.addr, o.we, o.be, o.wdata); end
    checks++; if ({o.if_gnt, o.d_gnt, o.if_rv, o.d_rv, o.busy} !== 5'b01011) begin errors++; $display("FAIL write_hs: ifgnt,dgnt,ifrv,drv,busy=%b want 01011", {o.if_gnt, o.d_gnt, o.if_rv, o.d_rv, o.busy}); end
    checks++; if (o.if_rd !== m_if_rd) begin errors++; $display("FAIL write_if_hold: if_rdata=%h want %h", o.if_rd, m_if_rd); end
    checks++; if ({d_gnt_n - g_d, d_rv_n - v_d, if_gnt_n - g_if, if_rv_n - v_if} !== {32'd1, 32'd1, 32'd0, 32'd0}) begin errors++; $display("FAIL write_pulses: dgnt=%0d drv=%0d ifgnt=%0d ifrv=%0d want 1 1 0 0", d_gnt_n - g_d, d_rv_n - v_d, if_gnt_n - g_if, if_rv_n - v_if); end
    model_done(1'b1, 32'h0000_A5A5);
    d_we_i = 1'b0;
  endtask

  task automatic test_contention();
    obs_t o;
    bit e1, e2;
    logic [31:0] rd;
    for (int r = 0; r < 2; r++) begin
      if_addr_i = 32'h0; d_addr_i = 32'h40; d_we_i = 1'b0; d_be_i = 4'hF;
      if_req_i = 1'b1; d_req_i = 1'b1;
      e1 = pick_d(1'b1, 1'b1, m_rr_last_d);
      rd = $urandom();
      run_txn(0, 1, rd, e1, o);
      checks++; if (o.timeout !== 1'b0 || o.addr !== (e1 ? 32'h40 : 32'h0)) begin errors++; $display("FAIL contend_first_%0d: timeout=%0d addr=%h want %h", r, o.timeout, o.addr, e1 ? 32'h40 : 32'h0); end
      checks++; if ({o.d_gnt, o.d_rv} !== {e1, e1}) begin errors++; $display("FAIL contend_owner_%0d: dgnt,drv=%b%b want %b%b", r, o.d_gnt, o.d_rv, e1, e1); end
      if (!o.timeout) model_done(e1, rd);
      e2 = pick_d(e1, !e1, m_rr_last_d);
      rd = $urandom();
      run_txn(0, 1, rd, e2, o);
      checks++; if (o.timeout !== 1'b0 || o.addr !== (e2 ? 32'h40 : 32'h0)) begin errors++; $display("FAIL contend_second_%0d: timeout=%0d addr=%h want %h", r, o.timeout, o.addr, e2 ? 32'h40 : 32'h0); end
      if (!o.timeout) model_done(e2, rd);
    end
  endtask

  task automatic test_stray_response();
    obs_t o;
    logic [31:0] rd;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_AAAA; #1;
    checks++; if ({if_rvalid_o, d_rvalid_o} !== 2'b00) begin errors++; $display("FAIL stray_idle: rvalids=%b want 00", {if_rvalid_o, d_rvalid_o}); end
    @(negedge clk_i); mem_rvalid_i = 1'b0; #1;
    checks++; if ({busy_o, if_rdata_o, d_rdata_o} !== {1'b0, m_if_rd, m_d_rd}) begin errors++; $display("FAIL stray_idle_state: busy=%b if=%h d=%h want 0 %h %h", busy_o, if_rdata_o, d_rdata_o, m_if_rd, m_d_rd); end
    if_req_i = 1'b1; if_addr_i = 32'h300;
    @(negedge clk_i); #1;
    mem_rvalid_i = 1'b1; #1;
    checks++; if ({mem_req_o, if_rvalid_o, d_rvalid_o} !== 3'b100) begin errors++; $display("FAIL stray_req: memreq,ifrv,drv=%b want 100", {mem_req_o, if_rvalid_o, d_rvalid_o}); end
    @(negedge clk_i); mem_rvalid_i = 1'b0; #1;
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL stray_req_state: mem_req_o=%b want 1", mem_req_o); end
    rd = $urandom();
    run_txn(0, 1, rd, 1'b0, o);
    checks++; if ({o.timeout, o.addr, o.if_rd} !== {1'b0, 32'h300, rd}) begin errors++; $display("FAIL stray_recover: timeout=%0d addr=%h rdata=%h want 0 300 %h", o.timeout, o.addr, o.if_rd, rd); end
    if (!o.timeout) model_done(1'b0, rd);
  endtask

  task automatic test_reset_mid_resp();
    obs_t o;
    int v_if, v_d;
    logic [31:0] rd;
    v_if = if_rv_n; v_d = d_rv_n;
    if_req_i = 1'b1; if_addr_i = 32'h500;
    @(negedge clk_i); #1;
    mem_gnt_i = 1'b1; #1;
    checks++; if ({mem_req_o, if_gnt_o} !== 2'b11) begin errors++; $display("FAIL rst_mid_gnt: memreq,ifgnt=%b want 11", {mem_req_o, if_gnt_o}); end
    @(negedge clk_i); mem_gnt_i = 1'b0; if_req_i = 1'b0; #1;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: busy=%b want 1", busy_o); end
    rst_i = 1'b1;
    @(negedge clk_i); rst_i = 1'b0; #1;
    model_reset();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: busy=%b want 0", busy_o); end
    @(negedge clk_i); mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0; #1;
    checks++; if ({if_rvalid_o, d_rvalid_o, busy_o, if_rdata_o} !== {3'b000, 32'h0}) begin errors++; $display("FAIL rst_mid_late: ifrv,drv,busy=%b if_rdata=%h want 000 0", {if_rvalid_o, d_rvalid_o, busy_o}, if_rdata_o); end
    @(negedge clk_i); mem_rvalid_i = 1'b0; #1;
    checks++; if ({if_rv_n - v_if, d_rv_n - v_d} !== {32'd0, 32'd0}) begin errors++; $display("FAIL rst_mid_pulses: ifrv=%0d drv=%0d want 0 0", if_rv_n - v_if, d_rv_n - v_d); end
    if_req_i = 1'b1; if_addr_i = 32'h600; rd = $urandom();
    run_txn(1, 1, rd, 1'b0, o);
    checks++; if ({o.timeout, o.addr, o.if_gnt, o.if_rv, o.if_rd} !== {1'b0, 32'h600, 1'b1, 1'b1, rd}) begin errors++; $display("FAIL rst_mid_next: timeout=%0d addr=%h gnt=%b rv=%b rdata=%h want 0 600 1 1 %h", o.timeout, o.addr, o.if_gnt, o.if_rv, o.if_rd, rd); end
    if (!o.timeout) model_done(1'b0, rd);
  endtask

  task automatic test_back_to_back();
    obs_t o;
    int prev;
    logic [31:0] rd;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      if_req_i = 1'b1; if_addr_i = 32'h1000 + 32'(4 * i); rd = $urandom();
      run_txn(0, 1, rd, 1'b0, o);
      checks++; if ({o.timeout, o.addr, o.if_rd} !== {1'b0, 32'h1000 + 32'(4 * i), rd}) begin errors++; $display("FAIL b2b_%0d: timeout=%0d addr=%h rdata=%h want 0 %h %h", i, o.timeout, o.addr, o.if_rd, 32'h1000 + 32'(4 * i), rd); end
      if (i > 0) begin
        checks++; if (o.start - prev !== 3) begin errors++; $display("FAIL b2b_spacing_%0d: %0d cycles want 3", i, o.start - prev); end
      end
      prev = o.start;
      if (!o.timeout) model_done(1'b0, rd);
    end
  endtask

  task automatic test_random();
    obs_t o;
    bit ed;
    int pat, guard;
    logic [31:0] rd, exp_if, exp_d;
    for (int it = 0; it < 24; it++) begin
      pat = int'($urandom_range(2, 0));
      if_addr_i = $urandom() & 32'hFFFF_FFFC; d_addr_i = $urandom();
      d_we_i = 1'($urandom_range(1, 0)); d_be_i = 4'($urandom_range(15, 0)); d_wdata_i = $urandom();
      if_req_i = (pat != 1); d_req_i = (pat != 0);
      guard = 0;
      while ((if_req_i || d_req_i) && guard < 3) begin
        guard++;
        ed = pick_d(if_req_i, d_req_i, m_rr_last_d);
        rd = $urandom();
        run_txn(int'($urandom_range(3, 0)), int'($urandom_range(3, 1)), rd, ed, o);
        checks++; if (o.timeout !== 1'b0) begin errors++; $display("FAIL rand_timeout_%0d: no mem_req_o within %0d cycles", it, LIMIT); break; end
        checks++; if ({o.addr, o.we, o.be, o.wdata} !== (ed ? {d_addr_i, d_we_i, d_be_i, d_wdata_i} : {if_addr_i, 1'b0, 4'hF, 32'h0})) begin errors++; $display("FAIL rand_mem_%0d: owner_d=%0d addr=%h we=%b be=%h wdata=%h", it, ed, o.addr, o.we, o.be, o.wdata); end
        checks++; if ({o.if_gnt, o.d_gnt, o.if_rv, o.d_rv} !== {!ed, ed, !ed, ed}) begin errors++; $display("FAIL rand_hs_%0d: ifgnt,dgnt,ifrv,drv=%b want %b", it, {o.if_gnt, o.d_gnt, o.if_rv, o.d_rv}, {!ed, ed, !ed, ed}); end
        exp_if = ed ? m_if_rd : rd;
        exp_d = ed ? rd : m_d_rd;
        checks++; if ({o.if_rd, o.d_rd} !== {exp_if, exp_d}) begin errors++; $display("FAIL rand_rdata_%0d: if=%h d=%h want %h %h", it, o.if_rd, o.d_rd, exp_if, exp_d); end
        model_done(ed, rd);
      end
    end
    if_req_i = 1'b0; d_req_i = 1'b0;
  endtask

  initial begin
    test_reset();
    @(negedge clk_i);
    test_single_fetch();
    test_data_write();
    test_contention();
    test_stray_response();
    test_reset_mid_resp();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
